// File: rtl/program_loader_if.sv
// program_loader_if
//   Byte-stream input and memory write port of the boot loader.
//   Stream:  in_valid/in_data from the source, in_ready back to it.
//   Memory:  mem_we/mem_addr/mem_wdata toward the CPU's unified memory.
// Modports:
//   slave  - the loader (consumes the stream, drives the write port)
//   master - the environment (drives the stream, observes the write port)
interface program_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader in front of the single-cycle CPU. Collects a
//   big-endian byte stream into 32-bit words: first word is the image
//   length N, then N data words written to BASE_ADDR + 4*i. The CPU is
//   held in reset (cpu_rst=1) until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra word (wrapping 32-bit sum of the data words)
//   follows the image; a mismatch aborts into the error state.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus           program_loader_if.slave (byte stream + memory write port)
//   cpu_rst       1 = CPU and PC held in reset
//   done          image loaded, CPU released
//   error         load aborted, CPU stays held
//   words_loaded  number of data words written so far
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  program_loader_if.slave         bus,
  output logic                    cpu_rst,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR, LOAD, CHK, RUN, ERR} state_t;
  localparam state_t IMAGE_END = CHK;
`else
  typedef enum logic [2:0] {HDR, LOAD, RUN, ERR} state_t;
  localparam state_t IMAGE_END = RUN;
`endif

  state_t      state_reg, state_next;
  logic [1:0]  byte_cnt_reg;
  logic [23:0] shift_reg;       // first three bytes of the word in flight
  logic [15:0] len_reg, len_next;
  logic [15:0] idx_reg, idx_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [15:0] words_loaded_reg;
  logic        cpu_rst_reg, done_reg, error_reg;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_reg, sum_next;
`endif

  logic        accepting;
  logic        accept;
  logic        word_done;
  logic [31:0] word;

  always_comb begin
    accepting = (state_reg == HDR) || (state_reg == LOAD);
`ifdef LOADER_CHECKSUM_EN
    accepting = accepting || (state_reg == CHK);
`endif
    bus.in_ready = accepting && !rst;
    accept       = bus.in_valid && bus.in_ready;
    word_done    = accept && (byte_cnt_reg == 2'd3);
    word         = {shift_reg, bus.in_data};

    state_next     = state_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
`ifdef LOADER_CHECKSUM_EN
    sum_next       = sum_reg;
`endif

    if (word_done) begin
      case (state_reg)
        HDR: begin
          if (word > 32'(MAX_WORDS)) begin
            state_next = ERR;
          end else if (word == 32'd0) begin
            state_next = IMAGE_END;
          end else begin
            state_next = LOAD;
            len_next   = word[15:0];
          end
        end
        LOAD: begin
          mem_we_next    = 1'b1;
          mem_addr_next  = BASE_ADDR + {14'd0, idx_reg, 2'b00};
          mem_wdata_next = word;
          idx_next       = idx_reg + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_next       = sum_reg + word;
`endif
          if (idx_reg + 16'd1 == len_reg) state_next = IMAGE_END;
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: state_next = (word == sum_reg) ? RUN : ERR;
`endif
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= HDR;
      byte_cnt_reg     <= 2'd0;
      shift_reg        <= 24'd0;
      len_reg          <= 16'd0;
      idx_reg          <= 16'd0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= BASE_ADDR;
      mem_wdata_reg    <= 32'd0;
      words_loaded_reg <= 16'd0;
      cpu_rst_reg      <= 1'b1;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg          <= 32'd0;
`endif
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
`ifdef LOADER_CHECKSUM_EN
      sum_reg       <= sum_next;
`endif
      if (accept) begin
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
        shift_reg    <= {shift_reg[15:0], bus.in_data};
      end
      // The visible count trails the write strobe by one cycle.
      if (mem_we_reg) words_loaded_reg <= words_loaded_reg + 16'd1;
      // Status is registered from the state, so release/abort appear one
      // edge after the deciding word completes.
      cpu_rst_reg <= (state_reg != RUN);
      done_reg    <= (state_reg == RUN);
      error_reg   <= (state_reg == ERR);
    end
  end

  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign cpu_rst       = cpu_rst_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign words_loaded  = words_loaded_reg;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader: reset values, back-to-back load,
//   empty image, oversize image, gapped stream, abort-and-reload.
//   Honours LOADER_CHECKSUM_EN when the design is built with it.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rst, done, error;
  logic [15:0] words_loaded;

  program_loader_if bus();

  program_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cpu_rst(cpu_rst), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write log, one entry per cycle in which mem_we is high.
  int          wr_cnt = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && wr_cnt < 64) begin
      wr_addr[wr_cnt] = bus.mem_addr;
      wr_data[wr_cnt] = bus.mem_wdata;
      $display("write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int base;
  logic [31:0] gw [3];
  logic [7:0]  gb;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick();
    tick();

    // ---- reset values
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    rst = 1'b0;
    #1;
    check("hdr_in_ready", bus.in_ready, 1);
    $display("step reset checked");

    // ---- N=2 back-to-back
    base = wr_cnt;
    send_word(32'd2);
    send_word(32'h20080005);
    check("n2_w0_we", bus.mem_we, 1);
    check("n2_w0_addr", bus.mem_addr, 32'h0);
    check("n2_w0_data", bus.mem_wdata, 32'h20080005);
    check("n2_w0_words", words_loaded, 0);
    check("n2_w0_ready", bus.in_ready, 1);
    send_byte(8'h8C, 0);
    check("n2_gap_we", bus.mem_we, 0);
    check("n2_hold_addr", bus.mem_addr, 32'h0);
    check("n2_words1", words_loaded, 1);
    send_byte(8'h09, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("n2_w1_we", bus.mem_we, 1);
    check("n2_w1_addr", bus.mem_addr, 32'h4);
    check("n2_w1_data", bus.mem_wdata, 32'h8C090000);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hAC110005);
`endif
    check("n2_pre_done", done, 0);
    check("n2_pre_cpu_rst", cpu_rst, 1);
    tick();
    check("n2_done", done, 1);
    check("n2_cpu_rst", cpu_rst, 0);
    check("n2_words2", words_loaded, 2);
    check("n2_in_ready", bus.in_ready, 0);
    check("n2_wr_cnt", wr_cnt - base, 2);
    check("n2_log0", wr_addr[base], 32'h0);
    check("n2_log1", wr_addr[base+1], 32'h4);
    $display("step n2 checked");

    // ---- N=0
    do_reset();
    base = wr_cnt;
    send_word(32'd0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'd0);
`endif
    check("n0_pre_done", done, 0);
    tick();
    check("n0_done", done, 1);
    check("n0_cpu_rst", cpu_rst, 0);
    check("n0_error", error, 0);
    check("n0_wr_cnt", wr_cnt - base, 0);
    $display("step n0 checked");

    // ---- N=257 oversize
    do_reset();
    base = wr_cnt;
    send_word(32'd257);
    check("big_in_ready", bus.in_ready, 0);
    check("big_pre_error", error, 0);
    tick();
    check("big_error", error, 1);
    check("big_cpu_rst", cpu_rst, 1);
    send_word(32'd1);
    send_word(32'h12345678);
    tick();
    check("big_wr_cnt", wr_cnt - base, 0);
    check("big_done", done, 0);
    check("big_error_hold", error, 1);
    check("big_words", words_loaded, 0);
    $display("step oversize checked");

    // ---- N=3 with gaps, including inside words
    do_reset();
    base = wr_cnt;
    gw[0] = 32'h11223344;
    gw[1] = 32'hAABBCCDD;
    gw[2] = 32'hDEADBEEF;
    for (int k = 3; k >= 0; k--) send_byte(8'(32'd3 >> (8*k)), k % 2);
    for (int w = 0; w < 3; w++) begin
      for (int k = 3; k >= 0; k--) begin
        gb = gw[w][8*k +: 8];
        send_byte(gb, (k == 2) ? 2 : ((k == 0) ? 1 : 0));
      end
    end
    check("gap_w2_we", bus.mem_we, 1);
    check("gap_w2_addr", bus.mem_addr, 32'h8);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h9A8BBF10);
`endif
    tick();
    check("gap_done", done, 1);
    check("gap_words", words_loaded, 3);
    check("gap_wr_cnt", wr_cnt - base, 3);
    for (int w = 0; w < 3; w++) begin
      check("gap_log_addr", wr_addr[base+w], 32'(4*w));
      check("gap_log_data", wr_data[base+w], gw[w]);
    end
    $display("step gapped checked");

    // ---- abort after 5 bytes, then full reload
    do_reset();
    base = wr_cnt;
    send_word(32'd2);
    send_byte(8'hEE, 0);
    rst = 1'b1;
    tick();
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_words", words_loaded, 0);
    check("abort_cpu_rst", cpu_rst, 1);
    check("abort_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    send_word(32'd2);
    send_word(32'hCAFEF00D);
    send_word(32'h01020304);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hCC00F311);
`endif
    tick();
    check("reload_done", done, 1);
    check("reload_wr_cnt", wr_cnt - base, 2);
    check("reload_a0", wr_addr[base], 32'h0);
    check("reload_d0", wr_data[base], 32'hCAFEF00D);
    check("reload_a1", wr_addr[base+1], 32'h4);
    check("reload_d1", wr_data[base+1], 32'h01020304);
    $display("step abort/reload checked");

`ifdef LOADER_CHECKSUM_EN
    // ---- checksum mismatch then match
    do_reset();
    base = wr_cnt;
    send_word(32'd1);
    send_word(32'h00000001);
    send_word(32'h00000002);
    tick();
    check("cks_bad_error", error, 1);
    check("cks_bad_done", done, 0);
    check("cks_bad_wr", wr_cnt - base, 1);
    do_reset();
    send_word(32'd1);
    send_word(32'h00000001);
    send_word(32'h00000001);
    tick();
    check("cks_ok_done", done, 1);
    check("cks_ok_error", error, 0);
    $display("step checksum checked");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader upstream of the single-cycle CPU. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into the CPU's unified memory through a dedicated write port. While loading it holds the CPU and PC in reset. When the image is complete it releases them so execution starts at the load base.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word; must be word-aligned.
- MAX_WORDS, 256: largest accepted image size, in words.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte; big-endian within each word.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  32  write byte address.
- mem_wdata  out  32  write data.
- cpu_rst  out  1  drives both CPU rst and rstPC; 1 means the CPU is held in reset.
- done  out  1  image loaded; CPU released.
- error  out  1  load aborted; CPU stays held.
- words_loaded  out  16  count of data words written so far.

## Operation
- A byte transfers on a rising edge where in_valid and in_ready are both 1. Nothing else advances the byte counter.
- A 2-bit byte counter shifts each accepted byte into a 32-bit shift register. The first byte lands in bits [31:24]. The 4th accepted byte completes the word.
- States and transitions:
  - HDR: the completed word is the image length N (full 32 bits).
    - N > MAX_WORDS → ERR.
    - N == 0 → CHK if LOADER_CHECKSUM_EN is defined, else RUN.
    - Otherwise → LOAD.
  - LOAD: each completed word i (0-based) is written to BASE_ADDR + 4*i. words_loaded increments with each write. After word N-1 → CHK if LOADER_CHECKSUM_EN is defined, else RUN.
  - CHK: the completed word is compared with the checksum. Equal → RUN; not equal → ERR.
  - RUN: cpu_rst=0, done=1.
  - ERR: error=1, cpu_rst=1.
- in_ready = 1 in HDR, LOAD and CHK; 0 in RUN, ERR and while rst=1. Bytes offered in RUN or ERR are ignored.
- Address arithmetic is 32-bit and wraps modulo 2^32, no error. N ≤ MAX_WORDS ≤ 65535 guarantees words_loaded never wraps.
- RUN and ERR are terminal. The only exit is rst.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, error=0, words_loaded=0. The state after reset is HDR, byte counter 0.
- Write latency:
  - The 4th byte of a data word is accepted at edge T.
  - mem_we=1 with the matching mem_addr/mem_wdata during cycle T..T+1, exactly one cycle.
  - words_loaded shows the new count from T+1.
- mem_addr and mem_wdata hold their last value while mem_we=0.
- Throughput: one byte per cycle sustained. in_ready does not drop during a write pulse.
- Release: cpu_rst falls and done rises in the same cycle.
  - Checksum disabled: that cycle is the one after the last data word's write pulse begins, i.e. edge T+1. For N=0, the edge after the header completes.
  - Checksum enabled: the edge after the checksum word completes and matches.
- Error: error rises on the edge after the offending word completes. cpu_rst never falls.
- rst=1 mid-load aborts on the next edge. The partial word and counters are discarded, memory already written is left as is, and all outputs return to reset values.
- in_valid may drop between any bytes, including inside a word. The partial word is retained.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the N data words the stream carries one extra word: the 32-bit wrapping sum of all data words. The header is not included in the sum; for N=0 the checksum is 0.
  - Mismatch → ERR.
- LOADER_CHECKSUM_EN undefined:
  - No CHK state and no accumulator.
  - The stream ends after the last data word.
  - error is asserted only for N > MAX_WORDS.

## Test plan
- N=2, data 0x20080005, 0x8C090000, sent back-to-back without bubbles (plus checksum 0xAC110005 when enabled) → expected response:
  - writes (0x0, 0x20080005) then (0x4, 0x8C090000);
  - words_loaded=2;
  - cpu_rst falls and done=1 on the expected edge.
- N=0 (plus checksum 0 when enabled) → no mem_we pulse, done=1, error=0.
- N=257 with MAX_WORDS=256 → no writes, error=1, cpu_rst stays 1, in_ready=0, and subsequent bytes are ignored.
- N=3 with random in_valid gaps, including mid-word → same writes and addresses as gap-free, one pulse per word.
- rst asserted after 5 accepted bytes of an N=2 image, then a full reload → HDR restarts, and the only new writes are from the second load, starting at 0x0.
- LOADER_CHECKSUM_EN: N=1, data 0x00000001, checksum 0x00000002 → one write, then error=1 and done=0. Correct checksum 0x00000001 → done=1.
